multi_pulse_cleaner: RTL
========================

MULTI_PULSE_CLEANER -- requirements
Module: multi_pulse_cleaner

Interface
REQ-001 Parameter CHANNELS, default 4, SHALL set the number of independent input channels (legal range 1..32).
REQ-002 Parameter DEBOUNCE_CNT_MAX, default 4, SHALL set the consecutive synchronized samples required to accept a level change (legal range 1..65535).
REQ-003 Parameter CNT_W, default 8, SHALL set the width of each per-channel event counter (legal range 1..32).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset, synchronous and active-low.
REQ-006 noisy_in  input  CHANNELS  SHALL carry the asynchronous raw inputs, bit i = channel i.
REQ-007 mode  input  2  SHALL select pulse generation: 00 rising, 01 falling, 10 both edges, 11 pulses disabled.
REQ-008 clear  input  1  SHALL zero all event counters and glitch flags, one cycle, synchronous.
REQ-009 clean_level  output  CHANNELS  SHALL carry the debounced level per channel.
REQ-010 clean_pulse  output  CHANNELS  SHALL carry one-cycle, mode-qualified edge pulses per channel.
REQ-011 event_count  output  CHANNELS*CNT_W  SHALL carry per-channel event counts, channel i at bits [i*CNT_W +: CNT_W].
REQ-012 glitch_flag  output  CHANNELS  SHALL carry sticky per-channel flags: a rejected glitch was seen.

Function
REQ-013 Each channel SHALL pass noisy_in[i] through a 2-flop synchronizer; sync output is s[i].
REQ-014 Each channel SHALL hold a stability counter of width clog2(DEBOUNCE_CNT_MAX+1), with no wrap.
REQ-015 When s[i] != clean_level[i] and counter < DEBOUNCE_CNT_MAX-1, the counter SHALL increment.
REQ-016 When s[i] != clean_level[i] and counter == DEBOUNCE_CNT_MAX-1, clean_level[i] SHALL toggle and the counter SHALL return to 0 on that edge.
REQ-017 When s[i] == clean_level[i], the counter SHALL clear to 0; if it was nonzero, glitch_flag[i] SHALL set on that edge.
REQ-018 Latency: clean_level[i] SHALL change on the (DEBOUNCE_CNT_MAX+2)th rising edge counted from the first edge that samples the new noisy_in value, input held stable.
REQ-019 Input pulses stable for fewer than DEBOUNCE_CNT_MAX synchronized samples SHALL never change clean_level.
REQ-020 clean_pulse[i] SHALL be registered and high for exactly the first cycle in which clean_level[i] holds its new value, if that edge direction is enabled by mode.
REQ-021 mode is sampled on the edge that updates clean_level; a change SHALL affect only level transitions on later edges.
REQ-022 With mode 11, clean_level SHALL still track; clean_pulse and event_count SHALL not change.
REQ-023 event_count[i] SHALL increment by 1 on each edge where the new clean_pulse[i] is 1, saturating at 2^CNT_W-1.
REQ-024 clear simultaneous with a pulse SHALL give count 0; clear simultaneous with a glitch rejection SHALL give flag 0. Clear wins.
REQ-025 clear SHALL not affect clean_level, clean_pulse, synchronizers or stability counters.
REQ-026 Channels SHALL be fully independent; simultaneous events on any set of channels SHALL each be processed in the same cycle.

Reset
REQ-027 With rst_n low at a rising edge: synchronizers, stability counters, clean_level, clean_pulse, event_count and glitch_flag SHALL all go to 0.
REQ-028 Reset mid-debounce SHALL discard the partial count; after release, a channel whose input is already high SHALL need the full REQ-018 latency.
REQ-029 Reset SHALL take priority over clear and all other inputs.

Verification
REQ-030 Defaults, mode 00, ch0 high for 3 cycles then low -> clean_level[0] stays 0, clean_pulse[0] never asserts, glitch_flag[0]=1, event_count ch0=0.
REQ-031 Defaults, mode 00, ch0 high for 6 cycles -> clean_level[0] rises 6 edges after the first sampling edge; clean_pulse[0] high one cycle; event_count ch0=1; no pulse on the later fall.
REQ-032 mode 10, ch1 and ch2 toggled together with stable 8-cycle high and low phases, done 3 times -> each channel has 6 pulses, event_count=6, ch0/ch3 unchanged.
REQ-033 CNT_W=2, mode 00, 5 stable rising edges on ch3 -> event_count ch3 saturates at 3; clear asserted on the cycle of the 5th pulse -> count 0.
REQ-034 mode 11, stable 10-cycle pulse on ch0 -> clean_level[0] tracks; clean_pulse[0]=0; count unchanged.
REQ-035 rst_n low for 1 cycle at counter=2 of a rising transition -> all outputs 0; with input still high, clean_level rises exactly 6 edges after rst_n returns high.

Source files
------------

// File: rtl/multi_pulse_cleaner_if.sv
// Signal bundle between a multi_pulse_cleaner and its environment.
interface multi_pulse_cleaner_if #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned CNT_W    = 8
);
   logic [CHANNELS-1:0]       noisy_in;
   logic [1:0]                mode;
   logic                      clear;
   logic [CHANNELS-1:0]       clean_level;
   logic [CHANNELS-1:0]       clean_pulse;
   logic [CHANNELS*CNT_W-1:0] event_count;
   logic [CHANNELS-1:0]       glitch_flag;

   // Environment side: drives raw inputs and controls, observes results.
   modport master (
      output noisy_in, mode, clear,
      input  clean_level, clean_pulse, event_count, glitch_flag
   );

   // Cleaner side.
   modport slave (
      input  noisy_in, mode, clear,
      output clean_level, clean_pulse, event_count, glitch_flag
   );
endinterface

// File: rtl/multi_pulse_cleaner.sv
// Multi-channel input debouncer with edge pulses, event counters and glitch flags.
module multi_pulse_cleaner #(
   parameter int unsigned CHANNELS         = 4,
   parameter int unsigned DEBOUNCE_CNT_MAX = 4,
   parameter int unsigned CNT_W            = 8
) (
   input logic                   clk,
   input logic                   rst_n,
   multi_pulse_cleaner_if.slave  bus
);
   localparam int unsigned DB_W = $clog2(DEBOUNCE_CNT_MAX + 1);
   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CNT_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_SAT = '1;

   logic rise_en_c;
   logic fall_en_c;

   // Edge directions enabled by the current mode.
   assign rise_en_c = (bus.mode == 2'b00) || (bus.mode == 2'b10);
   assign fall_en_c = (bus.mode == 2'b01) || (bus.mode == 2'b10);

   for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
      logic             sync1_q;
      logic             sync2_q;
      logic [DB_W-1:0]  db_q;
      logic [DB_W-1:0]  db_d;
      logic             level_q;
      logic             level_d;
      logic             pulse_q;
      logic             pulse_d;
      logic             glitch_q;
      logic             glitch_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // Channel state: synchronizer, stability counter and registered outputs.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_q     <= '0;
            level_q  <= 1'b0;
            pulse_q  <= 1'b0;
            glitch_q <= 1'b0;
            cnt_q    <= '0;
         end else begin
            sync1_q  <= bus.noisy_in[g];
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            level_q  <= level_d;
            pulse_q  <= pulse_d;
            glitch_q <= glitch_d;
            cnt_q    <= cnt_d;
         end
      end

      // Debounce decision, pulse qualification, counting and clear.
      always_comb begin
         db_d     = db_q;
         level_d  = level_q;
         pulse_d  = 1'b0;
         glitch_d = glitch_q;
         cnt_d    = cnt_q;

         if (sync2_q != level_q) begin
            if (db_q == DB_LAST) begin
               level_d = ~level_q;
               db_d    = '0;
               pulse_d = level_q ? fall_en_c : rise_en_c;
            end else begin
               db_d = db_q + DB_W'(1);
            end
         end else begin
            db_d = '0;
            if (db_q != '0) begin
               glitch_d = 1'b1;
            end
         end

         if (pulse_d && (cnt_q != CNT_SAT)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end

         if (bus.clear) begin
            cnt_d    = '0;
            glitch_d = 1'b0;
         end
      end

      assign bus.clean_level[g]               = level_q;
      assign bus.clean_pulse[g]               = pulse_q;
      assign bus.glitch_flag[g]               = glitch_q;
      assign bus.event_count[g*CNT_W +: CNT_W] = cnt_q;
   end
endmodule
